// File: rtl/fft_stage_out_collector_pkg.sv
// Shared types and sizes for the FFT stage output collector.
package fft_pkg;
  localparam int DATA_WIDTH   = 13;
  localparam int NUM_LANE     = 16;
  localparam int FFT_N        = 512;
  localparam int FRAME_CYCLES = FFT_N / (2 * NUM_LANE);
  localparam int WC_W         = $clog2(FRAME_CYCLES);
  localparam int RC_W         = $clog2(2 * FRAME_CYCLES);

  // One <7.6> signed sample and one 16-lane bus of them
  typedef logic signed [DATA_WIDTH-1:0] sample_t;
  typedef sample_t [0:NUM_LANE-1]       lane_arr_t;

  typedef enum logic {W_IDLE = 1'b0, W_CAP  = 1'b1} wstate_e;
  typedef enum logic {R_IDLE = 1'b0, R_SEND = 1'b1} rstate_e;
endpackage

// File: rtl/fft_stage_out_collector_if.sv
// Stream interfaces: upstream butterfly stage -> collector, collector -> consumer.
interface fso_in_if;
  import fft_pkg::*;
  logic      alert_in;
  lane_arr_t din_R_add;
  lane_arr_t din_Q_add;
  lane_arr_t din_R_sub;
  lane_arr_t din_Q_sub;

  modport master (output alert_in, din_R_add, din_Q_add, din_R_sub, din_Q_sub);
  modport slave  (input  alert_in, din_R_add, din_Q_add, din_R_sub, din_Q_sub);
endinterface

interface fso_out_if;
  import fft_pkg::*;
  lane_arr_t dout_R;
  lane_arr_t dout_Q;
  logic      dout_valid;
  logic      dout_ready;
  logic      dout_last;

  modport master (output dout_R, dout_Q, dout_valid, dout_last, input  dout_ready);
  modport slave  (input  dout_R, dout_Q, dout_valid, dout_last, output dout_ready);
endinterface

// File: rtl/fft_stage_out_collector_bank.sv
// One frame buffer: FRAME_CYCLES beats of add+sub lanes, sync write, comb row read.
module frame_bank
  import fft_pkg::*;
(
  input  logic            clk,
  input  logic            i_we,
  input  logic [WC_W-1:0] i_waddr,
  input  lane_arr_t       i_R_add,
  input  lane_arr_t       i_Q_add,
  input  lane_arr_t       i_R_sub,
  input  lane_arr_t       i_Q_sub,
  input  logic [RC_W-1:0] i_raddr,
  output lane_arr_t       o_R,
  output lane_arr_t       o_Q
);
  lane_arr_t       r_R_add [FRAME_CYCLES];
  lane_arr_t       r_Q_add [FRAME_CYCLES];
  lane_arr_t       r_R_sub [FRAME_CYCLES];
  lane_arr_t       r_Q_sub [FRAME_CYCLES];
  logic [WC_W-1:0] w_beat;

  // Storage needs no reset: the full flags gate every read
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_R_add[i_waddr] <= i_R_add;
      r_Q_add[i_waddr] <= i_Q_add;
      r_R_sub[i_waddr] <= i_R_sub;
      r_Q_sub[i_waddr] <= i_Q_sub;
    end
  end

  // Row r maps to beat r/2; even rows are the add lanes, odd rows the sub lanes
  assign w_beat = i_raddr[RC_W-1:1];
  assign o_R    = i_raddr[0] ? r_R_sub[w_beat] : r_R_add[w_beat];
  assign o_Q    = i_raddr[0] ? r_Q_sub[w_beat] : r_Q_add[w_beat];
endmodule

// File: rtl/fft_stage_out_collector.sv
// Ping-pong frame collector: captures one FFT frame per alert, replays it as rows.
module fft_stage_out_collector
  import fft_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  fso_in_if.slave    s_in,
  fso_out_if.master  m_out,
  output logic       busy,
  output logic [1:0] err
);
  wstate_e         r_wstate, w_wstate_nxt;
  rstate_e         r_rstate, w_rstate_nxt;
  logic [WC_W-1:0] r_wc, w_wc_nxt;
  logic [RC_W-1:0] r_rc, w_rc_nxt;
  logic            r_wp, w_wp_nxt;
  logic            r_rp, w_rp_nxt;
  logic [1:0]      r_full;
  logic [1:0]      r_err;
  logic            w_we, w_set_full, w_clr_full, w_ovf, w_dup;
  logic [1:0]      w_set_mask, w_clr_mask;
  logic            w_valid;
  lane_arr_t       w_R0, w_Q0, w_R1, w_Q1;

  // Write side: start capture on alert into an empty bank, count beats, hand off when full
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_wc_nxt     = r_wc;
    w_wp_nxt     = r_wp;
    w_we         = 1'b0;
    w_set_full   = 1'b0;
    w_ovf        = 1'b0;
    w_dup        = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (s_in.alert_in) begin
          if (r_full[r_wp]) begin
            w_ovf = 1'b1;
          end else begin
            w_wstate_nxt = W_CAP;
            w_wc_nxt     = '0;
          end
        end
      end
      W_CAP: begin
        w_we     = 1'b1;
        w_wc_nxt = r_wc + 1'b1;
        w_dup    = s_in.alert_in;
        if (r_wc == WC_W'(FRAME_CYCLES - 1)) begin
          w_set_full   = 1'b1;
          w_wp_nxt     = ~r_wp;
          w_wstate_nxt = W_IDLE;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Read side: replay rows of bank[rp]; roll straight into the other bank when it is ready
  always_comb begin
    w_rstate_nxt = r_rstate;
    w_rc_nxt     = r_rc;
    w_rp_nxt     = r_rp;
    w_clr_full   = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (r_full[r_rp]) begin
          w_rstate_nxt = R_SEND;
          w_rc_nxt     = '0;
        end
      end
      R_SEND: begin
        if (m_out.dout_ready) begin
          if (r_rc == RC_W'(2 * FRAME_CYCLES - 1)) begin
            w_clr_full = 1'b1;
            w_rp_nxt   = ~r_rp;
            w_rc_nxt   = '0;
            if (!r_full[~r_rp]) w_rstate_nxt = R_IDLE;
          end else begin
            w_rc_nxt = r_rc + 1'b1;
          end
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Write and read never touch the same bank's flag in one cycle, so set/clear compose freely
  assign w_set_mask = {w_set_full & r_wp, w_set_full & ~r_wp};
  assign w_clr_mask = {w_clr_full & r_rp, w_clr_full & ~r_rp};

  // State, counters, bank pointers, full flags and sticky errors
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
      r_wc     <= '0;
      r_rc     <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_full   <= 2'b00;
      r_err    <= 2'b00;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;
      r_wc     <= w_wc_nxt;
      r_rc     <= w_rc_nxt;
      r_wp     <= w_wp_nxt;
      r_rp     <= w_rp_nxt;
      r_full   <= (r_full | w_set_mask) & ~w_clr_mask;
      r_err    <= r_err | {w_dup, w_ovf};
    end
  end

  frame_bank u_bank0 (
    .clk     (clk),
    .i_we    (w_we & ~r_wp),
    .i_waddr (r_wc),
    .i_R_add (s_in.din_R_add),
    .i_Q_add (s_in.din_Q_add),
    .i_R_sub (s_in.din_R_sub),
    .i_Q_sub (s_in.din_Q_sub),
    .i_raddr (r_rc),
    .o_R     (w_R0),
    .o_Q     (w_Q0)
  );

  frame_bank u_bank1 (
    .clk     (clk),
    .i_we    (w_we & r_wp),
    .i_waddr (r_wc),
    .i_R_add (s_in.din_R_add),
    .i_Q_add (s_in.din_Q_add),
    .i_R_sub (s_in.din_R_sub),
    .i_Q_sub (s_in.din_Q_sub),
    .i_raddr (r_rc),
    .o_R     (w_R1),
    .o_Q     (w_Q1)
  );

  // Row data is forced to zero whenever nothing is offered, so reset drives clean zeros
  assign w_valid          = (r_rstate == R_SEND);
  assign m_out.dout_valid = w_valid;
  assign m_out.dout_R     = w_valid ? (r_rp ? w_R1 : w_R0) : '0;
  assign m_out.dout_Q     = w_valid ? (r_rp ? w_Q1 : w_Q0) : '0;
  assign m_out.dout_last  = w_valid && (r_rc == RC_W'(2 * FRAME_CYCLES - 1));
  assign busy             = (r_wstate == W_CAP) | (|r_full);
  assign err              = r_err;
endmodule

// File: tb/tb_fft_stage_out_collector.sv
// Directed bench for fft_stage_out_collector: frame replay, backpressure, overflow, errors, reset.
module tb_fft_stage_out_collector;
  import fft_pkg::*;

  localparam int FC   = FRAME_CYCLES;
  localparam int ROWS = 2 * FRAME_CYCLES;

  typedef struct { int c; int f; } sched_t;

  logic clk = 1'b0;
  logic rstn;
  logic busy;
  logic [1:0] err;

  fso_in_if  in_if ();
  fso_out_if out_if ();

  fft_stage_out_collector dut (
    .clk   (clk),
    .rstn  (rstn),
    .s_in  (in_if),
    .m_out (out_if),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     rows, exp_row, first_valid, last_xfer;
  int     drv_beat, drv_fid, spur_cyc;
  bit     rdy_pat, rdy_const;
  sched_t sched_q[$];
  int     exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic chk_row(input string tag, input lane_arr_t obs, input lane_arr_t req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  // Hand pattern: R = frame*1024 + 16*beat + lane (+256 on sub), Q = -R
  function automatic int mag(input int f, input int b, input int l, input bit sub);
    return f * 1024 + 16 * b + l + (sub ? 256 : 0);
  endfunction

  task automatic exp_vals(input int f, input int r, output lane_arr_t eR, output lane_arr_t eQ);
    for (int l = 0; l < NUM_LANE; l++) begin
      eR[l] = sample_t'(mag(f, r / 2, l, r[0]));
      eQ[l] = sample_t'(-mag(f, r / 2, l, r[0]));
    end
  endtask

  task automatic drive_beat(input int f, input int b);
    for (int l = 0; l < NUM_LANE; l++) begin
      in_if.din_R_add[l] = sample_t'(mag(f, b, l, 1'b0));
      in_if.din_Q_add[l] = sample_t'(-mag(f, b, l, 1'b0));
      in_if.din_R_sub[l] = sample_t'(mag(f, b, l, 1'b1));
      in_if.din_Q_sub[l] = sample_t'(-mag(f, b, l, 1'b1));
    end
  endtask

  task automatic drive_idle();
    for (int l = 0; l < NUM_LANE; l++) begin
      in_if.din_R_add[l] = sample_t'(1500 + l);
      in_if.din_Q_add[l] = sample_t'(-1500 - l);
      in_if.din_R_sub[l] = sample_t'(1700 + l);
      in_if.din_Q_sub[l] = sample_t'(-1700 - l);
    end
  endtask

  // Every offered row must equal the next expected row; count transfers
  task automatic observe();
    lane_arr_t eR, eQ;
    if (out_if.dout_valid === 1'b1) begin
      if (first_valid < 0) first_valid = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_row_valid", 32'(out_if.dout_valid), 32'd0);
      end else begin
        exp_vals(exp_q[0], exp_row, eR, eQ);
        chk_row($sformatf("f%0d_row%0d_R", exp_q[0], exp_row), out_if.dout_R, eR);
        chk_row($sformatf("f%0d_row%0d_Q", exp_q[0], exp_row), out_if.dout_Q, eQ);
        chk($sformatf("f%0d_row%0d_last", exp_q[0], exp_row), 32'(out_if.dout_last),
            32'(exp_row == ROWS - 1));
      end
      if (out_if.dout_ready === 1'b1) begin
        rows++;
        last_xfer = cyc;
        if (exp_q.size() != 0) begin
          exp_row++;
          if (exp_row == ROWS) begin
            exp_row = 0;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  endtask

  // One cycle: observe mid-cycle, then drive the next cycle's inputs just after the edge
  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    cyc++;
    in_if.alert_in = 1'b0;
    if (drv_beat < FC) begin
      drive_beat(drv_fid, drv_beat);
      drv_beat++;
    end else begin
      drive_idle();
    end
    if (sched_q.size() != 0 && sched_q[0].c == cyc) begin
      in_if.alert_in = 1'b1;
      drv_fid  = sched_q[0].f;
      drv_beat = 0;
      void'(sched_q.pop_front());
    end
    if (spur_cyc == cyc) in_if.alert_in = 1'b1;
    out_if.dout_ready = rdy_pat ? (cyc % 4 == 0 || cyc % 4 == 3) : rdy_const;
  endtask

  task automatic run_rows(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && rows < n; i++) tick();
    chk(tag, 32'(rows), 32'(n));
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    sched_q.delete();
    exp_q.delete();
    exp_row = 0; rows = 0; first_valid = -1; last_xfer = -1;
    drv_beat = FC; drv_fid = 0; spur_cyc = -1;
    rdy_pat = 1'b0; rdy_const = 1'b1;
    in_if.alert_in = 1'b0;
    out_if.dout_ready = 1'b1;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc  = 0;
  endtask

  initial begin
    // Reset state
    rstn = 1'b0;
    in_if.alert_in = 1'b0;
    out_if.dout_ready = 1'b0;
    drive_idle();
    #12;
    chk("rst_valid", 32'(out_if.dout_valid), 32'd0);
    chk("rst_last",  32'(out_if.dout_last),  32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_err",   32'(err),  32'd0);
    chk_row("rst_R", out_if.dout_R, '0);
    chk_row("rst_Q", out_if.dout_Q, '0);

    // Single frame, ready held high: valid at 10+18, then 32 rows, busy drops after
    do_reset();
    sched_q.push_back('{10, 0});
    exp_q.push_back(0);
    run_rows("single_rows", ROWS, 100);
    chk("single_first_valid", 32'(first_valid), 32'd28);
    chk("single_last_xfer",   32'(last_xfer),   32'd59);
    chk("single_busy_after",  32'(busy), 32'd0);
    chk("single_valid_after", 32'(out_if.dout_valid), 32'd0);
    chk("single_err", 32'(err), 32'd0);

    // Backpressure 1,0,0,1: rows must hold through stalls, none lost or duplicated
    do_reset();
    rdy_pat = 1'b1;
    sched_q.push_back('{10, 1});
    exp_q.push_back(1);
    run_rows("bp_rows", ROWS, 200);
    chk("bp_first_valid", 32'(first_valid), 32'd28);
    repeat (6) tick();
    chk("bp_rows_after", 32'(rows), 32'(ROWS));
    chk("bp_busy", 32'(busy), 32'd0);

    // Back-to-back frames: 64 rows on consecutive cycles
    do_reset();
    sched_q.push_back('{10, 0});
    sched_q.push_back('{27, 2});
    exp_q.push_back(0);
    exp_q.push_back(2);
    run_rows("b2b_rows", 2 * ROWS, 150);
    chk("b2b_first_valid", 32'(first_valid), 32'd28);
    chk("b2b_last_xfer",   32'(last_xfer),   32'd91);
    chk("b2b_err", 32'(err), 32'd0);

    // Overflow: consumer stalled, third frame dropped, then exactly two frames drain
    do_reset();
    rdy_const = 1'b0;
    out_if.dout_ready = 1'b0;
    sched_q.push_back('{10, 0});
    sched_q.push_back('{30, 1});
    sched_q.push_back('{50, 2});
    exp_q.push_back(0);
    exp_q.push_back(1);
    while (cyc < 70) tick();
    chk("ovf_err",  32'(err),  32'd1);
    chk("ovf_busy", 32'(busy), 32'd1);
    chk("ovf_rows_stalled", 32'(rows), 32'd0);
    rdy_const = 1'b1;
    out_if.dout_ready = 1'b1;
    run_rows("ovf_rows", 2 * ROWS, 150);
    repeat (10) tick();
    chk("ovf_rows_after", 32'(rows), 32'(2 * ROWS));
    chk("ovf_valid_after", 32'(out_if.dout_valid), 32'd0);
    chk("ovf_busy_after", 32'(busy), 32'd0);
    chk("ovf_err_after", 32'(err), 32'd1);

    // Alert during capture beat 5: flagged, frame intact, nothing else captured
    do_reset();
    sched_q.push_back('{10, 2});
    spur_cyc = 16;
    exp_q.push_back(2);
    while (cyc < 20) tick();
    chk("dup_err_mid", 32'(err),  32'd2);
    chk("dup_busy_mid", 32'(busy), 32'd1);
    run_rows("dup_rows", ROWS, 100);
    repeat (20) tick();
    chk("dup_rows_after", 32'(rows), 32'(ROWS));
    chk("dup_busy_after", 32'(busy), 32'd0);
    chk("dup_err_after", 32'(err), 32'd2);

    // Reset while row 7 is on the bus, then a clean frame afterwards
    do_reset();
    sched_q.push_back('{10, 1});
    exp_q.push_back(1);
    run_rows("rstmid_rows_before", 7, 100);
    rstn = 1'b0;
    #1;
    chk("rstmid_valid", 32'(out_if.dout_valid), 32'd0);
    chk("rstmid_last",  32'(out_if.dout_last),  32'd0);
    chk("rstmid_busy",  32'(busy), 32'd0);
    chk_row("rstmid_R", out_if.dout_R, '0);
    do_reset();
    sched_q.push_back('{10, 0});
    exp_q.push_back(0);
    run_rows("rstmid_rows_after", ROWS, 100);
    chk("rstmid_first_valid", 32'(first_valid), 32'd28);
    repeat (4) tick();
    chk("rstmid_rows_final", 32'(rows), 32'(ROWS));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
